rf_scoreboard_arb: RTL and testbench
====================================

Name: rf_scoreboard_arb

Overview:
- Issue-side scoreboard and write-port arbiter for the 8×16 register file of the 6-stage core.
- Tracks in-flight writes per architectural register and stalls issue on RAW or pending-count overflow by driving `freeze_ctrl`.
- Arbitrates the single register-file write port between the ALU writeback (`wb0`) and the load writeback (`wb1`).
- r0 holds the PC and is managed by the PC logic; it is never tracked or written through this block.

Parameters:
- DW, 16: data width.
- AW, 3: register address width (8 registers).
- MAXPEND, 3: maximum in-flight writes per register; counter width is 2 bits.
- STARVE, 2: consecutive contended losses by wb1 before wb1 gets forced priority.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  instruction present at issue.
- issue_ra  in  AW  source A register.
- issue_rb  in  AW  source B register.
- issue_use_a  in  1  source A is read.
- issue_use_b  in  1  source B is read.
- issue_wr  in  1  instruction writes a register.
- issue_rc  in  AW  destination register.
- issue_ready  out  1  issue accepted this cycle.
- freeze_ctrl  out  1  stall front end.
- wb0_valid  in  1  ALU writeback request.
- wb0_kill  in  1  request is squashed: release scoreboard entry only, no write.
- wb0_addr  in  AW  ALU writeback destination.
- wb0_data  in  DW  ALU writeback data.
- wb0_ready  out  1  ALU request accepted.
- wb1_valid  in  1  load writeback request.
- wb1_kill  in  1  load request is squashed.
- wb1_addr  in  AW  load writeback destination.
- wb1_data  in  DW  load writeback data.
- wb1_ready  out  1  load request accepted.
- rf_w  out  1  register-file write enable (registered).
- regsel  out  1  register-file select (registered; tied high after reset).
- addrc  out  AW  write address (registered).
- rf_data_c  out  DW  write data (registered).
- err_underflow  out  1  sticky: release seen on a zero counter.

Behaviour:
Reset:
- All counters 0; `rf_w`=0, `addrc`=0, `rf_data_c`=0, `regsel`=0, `err_underflow`=0.
- Starvation counter 0.
- `regsel` goes to 1 on the first cycle after rst deasserts.

Scoreboard:
- `busy[r]` = (`cnt[r]` != 0). r0 is never busy.
- `issue_ready` = `issue_valid` & ~(`use_a`&`busy[ra]`) & ~(`use_b`&`busy[rb]`) & ~(`issue_wr` & `rc`!=0 & `cnt[rc]`==MAXPEND).
- `freeze_ctrl` = `issue_valid` & ~`issue_ready` (combinational).
- An accepted issue with `issue_wr` and `rc`!=0 increments `cnt[rc]` at the clock edge.
- An issue with `rc`=0 is accepted but not tracked.

Release:
- A killed request is accepted in the cycle it is presented, regardless of arbitration. Its counter decrements at the end of that cycle.
- A non-killed request that wins arbitration in cycle N drives `rf_w`=1 with `addrc`/`rf_data_c` during cycle N+1. Its counter decrements at the end of N+1, so a dependent issue sees `issue_ready`=1 in cycle N+2, when the new data is readable.
- Non-killed requests with `addr`=0 are accepted, written nowhere (`rf_w` stays 0) and cause no decrement.

Same-cycle counter updates:
- Increment and decrement on the same register: net unchanged.
- Two decrements on the same register (kill plus write release): decrement by 2.
- Any decrement on a zero counter saturates at 0 and sets `err_underflow`.

Arbitration:
- Only non-killed requests contend; a kill never occupies the port.
- Fixed priority to wb0.
- Each cycle both non-killed requests are valid and wb1 loses, the starvation counter increments. When it reaches STARVE, wb1 wins the next contended cycle and the counter clears.
- The starvation counter also clears whenever wb1 is accepted.
- A loser holds `valid`/`addr`/`data` stable until `ready`.

Other:
- `rf_w`=0 in any cycle with no write winner in the previous cycle.
- Reset mid-operation: all pending state is discarded and the `rf_w` pulse is suppressed on the cycle after rst.

Test Plan:
1. Issue r3 write (`cnt[3]`=1); next cycle issue reading r3 → `freeze_ctrl`=1. wb0 writes r3 data 0x00AB at cycle N → `rf_w`=1, `addrc`=3, `rf_data_c`=0x00AB at N+1; `issue_ready`=1 at N+2.
2. wb0 (r2, 0x1111) and wb1 (r5, 0x2222) valid for 3 cycles → wb0 wins cycles 0 and 1, wb1 wins cycle 2, `starve` cleared.
3. wb0_kill on r4 with wb1 valid non-killed on r6, same cycle → both ready; `cnt[4]` decrements that edge; r6 write appears next cycle.
4. Three issues writing r1 → `cnt[1]`=3; fourth issue writing r1 → `issue_ready`=0 until one r1 release completes.
5. Issue writing r7 and wb0 release of r7 complete in the same edge with `cnt`=1 → `cnt[7]` stays 1. Release on r2 with `cnt`=0 → `err_underflow`=1, `cnt[2]`=0.
6. rst asserted while `cnt[3]`=2 and a write is pending → next cycle all counters 0, `rf_w`=0, `freeze_ctrl`=0 for an issue reading r3.

Source files
------------

// File: rtl/rf_scoreboard_arb.sv
// Issue scoreboard and write-port arbiter for the 8x16 register file.
// Counts in-flight writes per register, stalls issue on hazards, and muxes ALU/load writeback.
module rf_scoreboard_arb #(
    parameter int DW      = 16,
    parameter int AW      = 3,
    parameter int MAXPEND = 3,
    parameter int STARVE  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_ra,
    input  logic [AW-1:0] issue_rb,
    input  logic          issue_use_a,
    input  logic          issue_use_b,
    input  logic          issue_wr,
    input  logic [AW-1:0] issue_rc,
    output logic          issue_ready,
    output logic          freeze_ctrl,
    input  logic          wb0_valid,
    input  logic          wb0_kill,
    input  logic [AW-1:0] wb0_addr,
    input  logic [DW-1:0] wb0_data,
    output logic          wb0_ready,
    input  logic          wb1_valid,
    input  logic          wb1_kill,
    input  logic [AW-1:0] wb1_addr,
    input  logic [DW-1:0] wb1_data,
    output logic          wb1_ready,
    output logic          rf_w,
    output logic          regsel,
    output logic [AW-1:0] addrc,
    output logic [DW-1:0] rf_data_c,
    output logic          err_underflow
);
    localparam int NREG = 1 << AW;
    localparam int SW   = $clog2(STARVE + 1);

    logic [1:0]    r_cnt [NREG];
    logic [SW-1:0] r_starve;
    logic          r_rf_w;
    logic          r_regsel;
    logic          r_err;
    logic [AW-1:0] r_addrc;
    logic [DW-1:0] r_data;

    logic w_busy_a, w_busy_b, w_full, w_issue_ok, w_inc_en;
    logic w_req0, w_req1, w_win0, w_win1, w_kill0, w_kill1, w_under;
    logic [2:0] w_sum  [NREG];
    logic [2:0] w_dec  [NREG];
    logic [1:0] w_next [NREG];

    // r0 is never incremented, so its counter stays 0 and it never reads as busy.
    assign w_busy_a    = issue_use_a && (r_cnt[issue_ra] != 2'd0);
    assign w_busy_b    = issue_use_b && (r_cnt[issue_rb] != 2'd0);
    assign w_full      = issue_wr && (issue_rc != '0) && (r_cnt[issue_rc] == 2'(MAXPEND));
    assign w_issue_ok  = issue_valid && !w_busy_a && !w_busy_b && !w_full;
    assign w_inc_en    = w_issue_ok && issue_wr && (issue_rc != '0);
    assign issue_ready = w_issue_ok;
    assign freeze_ctrl = issue_valid && !w_issue_ok;

    // Kills bypass the port; wb1 overrides wb0 after STARVE consecutive contended losses.
    assign w_req0    = wb0_valid && !wb0_kill;
    assign w_req1    = wb1_valid && !wb1_kill;
    assign w_win1    = w_req1 && (!w_req0 || (r_starve == SW'(STARVE)));
    assign w_win0    = w_req0 && !w_win1;
    assign w_kill0   = wb0_valid && wb0_kill && (wb0_addr != '0);
    assign w_kill1   = wb1_valid && wb1_kill && (wb1_addr != '0);
    assign wb0_ready = wb0_valid && (wb0_kill || w_win0);
    assign wb1_ready = wb1_valid && (wb1_kill || w_win1);

    // A write releases its entry while rf_w is high, so dependents unblock once data is readable.
    always_comb begin
        w_under = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            w_sum[r] = {1'b0, r_cnt[r]} + {2'b00, w_inc_en && (issue_rc == AW'(r))};
            w_dec[r] = {2'b00, w_kill0 && (wb0_addr == AW'(r))}
                     + {2'b00, w_kill1 && (wb1_addr == AW'(r))}
                     + {2'b00, r_rf_w && (r_addrc == AW'(r))};
            if (w_sum[r] < w_dec[r]) begin
                w_next[r] = 2'd0;
                w_under   = 1'b1;
            end else begin
                w_next[r] = w_sum[r][1:0] - w_dec[r][1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) r_cnt[r] <= 2'd0;
            r_starve <= '0;
            r_rf_w   <= 1'b0;
            r_addrc  <= '0;
            r_data   <= '0;
            r_regsel <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) r_cnt[r] <= w_next[r];
            r_err    <= r_err || w_under;
            r_regsel <= 1'b1;
            r_rf_w   <= (w_win0 && (wb0_addr != '0)) || (w_win1 && (wb1_addr != '0));
            if (w_win0 && (wb0_addr != '0)) begin
                r_addrc <= wb0_addr;
                r_data  <= wb0_data;
            end else if (w_win1 && (wb1_addr != '0)) begin
                r_addrc <= wb1_addr;
                r_data  <= wb1_data;
            end
            if (wb1_ready)
                r_starve <= '0;
            else if (w_req0 && w_req1)
                r_starve <= r_starve + SW'(1);
        end
    end

    assign rf_w          = r_rf_w;
    assign regsel        = r_regsel;
    assign addrc         = r_addrc;
    assign rf_data_c     = r_data;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_rf_scoreboard_arb.sv
// Self-checking bench for rf_scoreboard_arb: directed scenarios followed by random traffic,
// compared every cycle against a per-register pending-count reference model.
module tb_rf_scoreboard_arb;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int MAXPEND = 3;
    localparam int STARVE = 2;

    logic clk = 1'b0;
    logic rst;
    logic issue_valid, issue_use_a, issue_use_b, issue_wr;
    logic [AW-1:0] issue_ra, issue_rb, issue_rc;
    logic issue_ready, freeze_ctrl;
    logic wb0_valid, wb0_kill, wb0_ready;
    logic [AW-1:0] wb0_addr;
    logic [DW-1:0] wb0_data;
    logic wb1_valid, wb1_kill, wb1_ready;
    logic [AW-1:0] wb1_addr;
    logic [DW-1:0] wb1_data;
    logic rf_w, regsel, err_underflow;
    logic [AW-1:0] addrc;
    logic [DW-1:0] rf_data_c;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: pending writes per register, starvation streak, one-deep write stage.
    int mCnt [8];
    int mStarve;
    bit mRfW, mRegsel, mErr;
    int mAddr, mData;
    bit eIssue, eWin0, eWin1, eReady0, eReady1;

    always #5 clk = ~clk;

    rf_scoreboard_arb #(.DW(DW), .AW(AW), .MAXPEND(MAXPEND), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ra(issue_ra), .issue_rb(issue_rb),
        .issue_use_a(issue_use_a), .issue_use_b(issue_use_b), .issue_wr(issue_wr),
        .issue_rc(issue_rc), .issue_ready(issue_ready), .freeze_ctrl(freeze_ctrl),
        .wb0_valid(wb0_valid), .wb0_kill(wb0_kill), .wb0_addr(wb0_addr),
        .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_kill(wb1_kill), .wb1_addr(wb1_addr),
        .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .rf_w(rf_w), .regsel(regsel), .addrc(addrc), .rf_data_c(rf_data_c),
        .err_underflow(err_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void computeExpected();
        bit c0, c1;
        eIssue = issue_valid
              && !(issue_use_a && mCnt[issue_ra] > 0)
              && !(issue_use_b && mCnt[issue_rb] > 0)
              && !(issue_wr && issue_rc != 0 && mCnt[issue_rc] >= MAXPEND);
        c0 = wb0_valid && !wb0_kill;
        c1 = wb1_valid && !wb1_kill;
        eWin1 = c1 && (!c0 || mStarve >= STARVE);
        eWin0 = c0 && !eWin1;
        eReady0 = wb0_valid && (wb0_kill || eWin0);
        eReady1 = wb1_valid && (wb1_kill || eWin1);
    endfunction

    function automatic void updateModel();
        int d [8];
        if (rst) begin
            foreach (mCnt[r]) mCnt[r] = 0;
            mStarve = 0; mRfW = 0; mAddr = 0; mData = 0; mRegsel = 0; mErr = 0;
            return;
        end
        foreach (d[r]) d[r] = 0;
        if (eIssue && issue_wr && issue_rc != 0) d[issue_rc] += 1;
        if (wb0_valid && wb0_kill && wb0_addr != 0) d[wb0_addr] -= 1;
        if (wb1_valid && wb1_kill && wb1_addr != 0) d[wb1_addr] -= 1;
        if (mRfW) d[mAddr] -= 1;
        foreach (mCnt[r]) begin
            if (mCnt[r] + d[r] < 0) begin
                mCnt[r] = 0;
                mErr = 1;
            end else begin
                mCnt[r] += d[r];
            end
        end
        if (eReady1) mStarve = 0;
        else if (wb0_valid && !wb0_kill && wb1_valid && !wb1_kill) mStarve++;
        if (eWin0 && wb0_addr != 0) begin
            mRfW = 1; mAddr = int'(wb0_addr); mData = int'(wb0_data);
        end else if (eWin1 && wb1_addr != 0) begin
            mRfW = 1; mAddr = int'(wb1_addr); mData = int'(wb1_data);
        end else begin
            mRfW = 0;
        end
        mRegsel = 1;
    endfunction

    task automatic checkOutput();
        check("issue_ready", 32'(issue_ready), 32'(eIssue));
        check("freeze_ctrl", 32'(freeze_ctrl), 32'(issue_valid && !eIssue));
        check("wb0_ready", 32'(wb0_ready), 32'(eReady0));
        check("wb1_ready", 32'(wb1_ready), 32'(eReady1));
        check("rf_w", 32'(rf_w), 32'(mRfW));
        check("addrc", 32'(addrc), 32'(mAddr));
        check("rf_data_c", 32'(rf_data_c), 32'(mData));
        check("regsel", 32'(regsel), 32'(mRegsel));
        check("err_underflow", 32'(err_underflow), 32'(mErr));
    endtask

    // Inputs are driven at the falling edge; outputs are sampled 1ns later.
    task automatic settle();
        #1;
        computeExpected();
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    task automatic setIssue(input logic v, input logic ua, input logic [2:0] ra,
                            input logic ub, input logic [2:0] rb,
                            input logic wr, input logic [2:0] rc);
        issue_valid = v; issue_use_a = ua; issue_ra = ra;
        issue_use_b = ub; issue_rb = rb; issue_wr = wr; issue_rc = rc;
    endtask

    task automatic setWb0(input logic v, input logic k, input logic [2:0] a, input logic [15:0] d);
        wb0_valid = v; wb0_kill = k; wb0_addr = a; wb0_data = d;
    endtask

    task automatic setWb1(input logic v, input logic k, input logic [2:0] a, input logic [15:0] d);
        wb1_valid = v; wb1_kill = k; wb1_addr = a; wb1_data = d;
    endtask

    task automatic idle();
        setIssue(0, 0, 0, 0, 0, 0, 0);
        setWb0(0, 0, 0, 16'h0);
        setWb1(0, 0, 0, 16'h0);
    endtask

    task automatic doReset();
        idle();
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
    endtask

    task automatic issueWrite(input logic [2:0] rc);
        setIssue(1, 0, 0, 0, 0, 1, rc);
        settle();
        advance();
    endtask

    function automatic logic [2:0] pickAddr();
        int live[$];
        for (int r = 1; r < 8; r++) if (mCnt[r] > 0) live.push_back(r);
        if (live.size() > 0 && $urandom_range(0, 3) != 0)
            return 3'(live[$urandom_range(0, live.size() - 1)]);
        return 3'($urandom_range(0, 7));
    endfunction

    // Random traffic; a non-accepted writeback request is held unchanged until accepted.
    task automatic applyStimulus();
        setIssue($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 1'($urandom),
                 3'($urandom), $urandom_range(0, 2) != 0, 3'($urandom));
        if (!wb0_valid || eReady0 || rst)
            setWb0($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, pickAddr(), 16'($urandom));
        if (!wb1_valid || eReady1 || rst)
            setWb1($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, pickAddr(), 16'($urandom));
        rst = ($urandom_range(0, 149) == 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        foreach (mCnt[r]) mCnt[r] = 0;
        mStarve = 0; mRfW = 0; mAddr = 0; mData = 0; mRegsel = 0; mErr = 0;
        eReady0 = 0; eReady1 = 0;
        @(posedge clk);
        @(negedge clk);
        doReset();
        $display("[TB] reset checked, starting directed scenarios");

        // RAW stall and write-to-read latency on r3
        issueWrite(3);
        setIssue(1, 1, 3, 0, 0, 0, 0);
        setWb0(1, 0, 3, 16'h00AB);
        settle();
        check("p1_freeze", 32'(freeze_ctrl), 32'd1);
        advance();
        setWb0(0, 0, 0, 16'h0);
        settle();
        check("p1_rf_w", 32'(rf_w), 32'd1);
        check("p1_addrc", 32'(addrc), 32'd3);
        check("p1_data", 32'(rf_data_c), 32'h00AB);
        check("p1_still_frozen", 32'(freeze_ctrl), 32'd1);
        advance();
        settle();
        check("p1_ready", 32'(issue_ready), 32'd1);
        advance();
        idle();

        // Starvation: wb0 wins twice, then wb1 is forced through
        issueWrite(2); issueWrite(2); issueWrite(2); issueWrite(5);
        idle();
        setWb0(1, 0, 2, 16'h1111);
        setWb1(1, 0, 5, 16'h2222);
        for (int c = 0; c < 2; c++) begin
            settle();
            check("p2_wb0_wins", 32'(wb0_ready), 32'd1);
            check("p2_wb1_loses", 32'(wb1_ready), 32'd0);
            advance();
        end
        settle();
        check("p2_wb0_loses", 32'(wb0_ready), 32'd0);
        check("p2_wb1_forced", 32'(wb1_ready), 32'd1);
        advance();
        setWb1(0, 0, 0, 16'h0);
        settle();
        check("p2_addrc", 32'(addrc), 32'd5);
        check("p2_data", 32'(rf_data_c), 32'h2222);
        check("p2_wb0_after", 32'(wb0_ready), 32'd1);
        advance();
        idle();
        settle();
        advance();

        // Kill on wb0 alongside a real wb1 write
        issueWrite(4); issueWrite(6);
        idle();
        setWb0(1, 1, 4, 16'hDEAD);
        setWb1(1, 0, 6, 16'h3333);
        settle();
        check("p3_kill_ready", 32'(wb0_ready), 32'd1);
        check("p3_wb1_ready", 32'(wb1_ready), 32'd1);
        advance();
        idle();
        setIssue(1, 1, 4, 0, 0, 0, 0);
        settle();
        check("p3_r4_free", 32'(issue_ready), 32'd1);
        check("p3_r6_write", 32'(addrc), 32'd6);
        advance();
        idle();
        settle();
        advance();

        // Pending-count overflow on r1
        issueWrite(1); issueWrite(1); issueWrite(1);
        setIssue(1, 0, 0, 0, 0, 1, 1);
        settle();
        check("p4_full", 32'(issue_ready), 32'd0);
        advance();
        setWb0(1, 0, 1, 16'h4444);
        settle();
        check("p4_full_n", 32'(issue_ready), 32'd0);
        advance();
        setWb0(0, 0, 0, 16'h0);
        settle();
        check("p4_full_n1", 32'(issue_ready), 32'd0);
        check("p4_rf_w", 32'(rf_w), 32'd1);
        advance();
        settle();
        check("p4_room_n2", 32'(issue_ready), 32'd1);
        advance();
        doReset();

        // Same-edge increment/decrement, then underflow
        issueWrite(7);
        idle();
        setWb0(1, 0, 7, 16'h5555);
        settle();
        advance();
        setWb0(0, 0, 0, 16'h0);
        setIssue(1, 0, 0, 0, 0, 1, 7);
        settle();
        check("p5_rf_w_r7", 32'(addrc), 32'd7);
        advance();
        setIssue(1, 1, 7, 0, 0, 0, 0);
        setWb0(1, 1, 2, 16'h0);
        settle();
        check("p5_r7_busy", 32'(freeze_ctrl), 32'd1);
        check("p5_err_before", 32'(err_underflow), 32'd0);
        advance();
        idle();
        setIssue(1, 1, 2, 0, 0, 0, 0);
        settle();
        check("p5_err_after", 32'(err_underflow), 32'd1);
        check("p5_r2_zero", 32'(issue_ready), 32'd1);
        advance();

        // Reset mid-operation discards pending state and the write pulse
        doReset();
        issueWrite(3); issueWrite(3);
        idle();
        setWb0(1, 0, 3, 16'h6666);
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
        idle();
        setIssue(1, 1, 3, 0, 0, 0, 0);
        settle();
        check("p6_rf_w", 32'(rf_w), 32'd0);
        check("p6_freeze", 32'(freeze_ctrl), 32'd0);
        advance();

        $display("[TB] directed scenarios done, starting random traffic");
        idle();
        for (int i = 0; i < 2000; i++) begin
            applyStimulus();
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
